// File: rtl/csr_regfile_if.sv
// Bus bundle between the pipeline/trap controller and the CSR register file:
// two write ports, one combinational read port and the status flags.
interface csr_regfile_if;
  logic        trap_we_i;
  logic [11:0] trap_waddr_i;
  logic [31:0] trap_wdata_i;
  logic        inst_we_i;
  logic [11:0] inst_waddr_i;
  logic [31:0] inst_wdata_i;
  logic [11:0] raddr_i;
  logic        rd_valid_i;
  logic [31:0] rdata_o;
  logic        illegal_o;
  logic        inst_drop_o;

  modport master (
    output trap_we_i, trap_waddr_i, trap_wdata_i,
    output inst_we_i, inst_waddr_i, inst_wdata_i,
    output raddr_i, rd_valid_i,
    input  rdata_o, illegal_o, inst_drop_o
  );

  modport slave (
    input  trap_we_i, trap_waddr_i, trap_wdata_i,
    input  inst_we_i, inst_waddr_i, inst_wdata_i,
    input  raddr_i, rd_valid_i,
    output rdata_o, illegal_o, inst_drop_o
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine/supervisor CSR storage with trap-port priority, WARL legalisation,
// supervisor masked views and 64-bit cycle/instret counters.
module csr_regfile #(
  parameter logic [31:0] MTVEC_RESET  = 32'h8000_0000,
  parameter logic [31:0] MISA_VAL     = 32'h4014_1101,
  parameter logic [31:0] SSTATUS_MASK = 32'h000C_0122
) (
  input  logic        clk,
  input  logic        rst,
  csr_regfile_if.slave bus,
  input  logic        priv_we_i,
  input  logic [1:0]  priv_i,
  output logic [1:0]  privilege_o,
  input  logic        mtip_i,
  input  logic        instret_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic [31:0] csr_mtval_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_medeleg_o,
  output logic [31:0] csr_mideleg_o,
  output logic [31:0] csr_stvec_o,
  output logic [31:0] csr_sepc_o,
  output logic [31:0] csr_scause_o,
  output logic [31:0] csr_stval_o,
  output logic [31:0] csr_sstatus_o,
  output logic [31:0] csr_sie_o,
  output logic [31:0] csr_sip_o,
  output logic [31:0] csr_satp_o
);

  // SSIP, STIP, SEIP are software-writable; MTIP comes from the timer only.
  localparam logic [31:0] MIP_SW_MASK = 32'h0000_0222;

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mip_q, mip_d;
  logic [31:0] medeleg_q, medeleg_d;
  logic [31:0] mideleg_q, mideleg_d;
  logic [31:0] stvec_q, stvec_d;
  logic [31:0] sepc_q, sepc_d;
  logic [31:0] scause_q, scause_d;
  logic [31:0] stval_q, stval_d;
  logic [31:0] satp_q, satp_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [1:0]  priv_q, priv_d;
  logic        mtip_q, mtip_d;
  logic        inst_drop_q, inst_drop_d;

  logic [11:0] w_addr_s;
  logic [31:0] w_data_s;
  logic [31:0] mip_view_s;
  logic [31:0] sstatus_view_s;
  logic [31:0] sie_view_s;
  logic [31:0] sip_view_s;
  logic [31:0] rdata_s;
  logic        illegal_s;

  function automatic logic addr_writable(input logic [11:0] a);
    case (a)
      12'h300, 12'h302, 12'h303, 12'h304, 12'h305,
      12'h341, 12'h342, 12'h343, 12'h344,
      12'h100, 12'h104, 12'h105, 12'h141, 12'h142, 12'h143, 12'h144, 12'h180,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: addr_writable = 1'b1;
      default:                             addr_writable = 1'b0;
    endcase
  endfunction

  function automatic logic addr_known(input logic [11:0] a);
    case (a)
      12'h301, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14: addr_known = 1'b1;
      default:                                            addr_known = addr_writable(a);
    endcase
  endfunction

  assign mip_view_s     = (mip_q & MIP_SW_MASK) | {24'h00_0000, mtip_q, 7'h00};
  assign sstatus_view_s = mstatus_q & SSTATUS_MASK;
  assign sie_view_s     = mie_q & mideleg_q;
  assign sip_view_s     = mip_view_s & mideleg_q;

  // Arbitrate the two write ports; address 0x000 is unmapped, so idle means no write.
  always_comb begin
    w_addr_s    = 12'h000;
    w_data_s    = 32'h0000_0000;
    inst_drop_d = 1'b0;
    if (bus.trap_we_i) begin
      w_addr_s    = bus.trap_waddr_i;
      w_data_s    = bus.trap_wdata_i;
      inst_drop_d = bus.inst_we_i;
    end else if (bus.inst_we_i) begin
      w_addr_s = bus.inst_waddr_i;
      w_data_s = bus.inst_wdata_i;
    end else begin
      w_addr_s = 12'h000;
    end
  end

  // Next-state for all CSRs; a counter half write replaces the increment that cycle.
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mtval_d   = mtval_q;
    mie_d     = mie_q;
    mip_d     = mip_q;
    medeleg_d = medeleg_q;
    mideleg_d = mideleg_q;
    stvec_d   = stvec_q;
    sepc_d    = sepc_q;
    scause_d  = scause_q;
    stval_d   = stval_q;
    satp_d    = satp_q;
    mcycle_d  = mcycle_q + 64'd1;
    mtip_d    = mtip_i;
    priv_d    = priv_we_i ? priv_i : priv_q;
    if (instret_i) begin
      minstret_d = minstret_q + 64'd1;
    end else begin
      minstret_d = minstret_q;
    end
    case (w_addr_s)
      12'h300: mstatus_d = {w_data_s[31:13],
                            (w_data_s[12:11] == 2'b10) ? mstatus_q[12:11] : w_data_s[12:11],
                            w_data_s[10:0]};
      12'h302: medeleg_d = w_data_s;
      12'h303: mideleg_d = w_data_s;
      12'h304: mie_d     = w_data_s;
      12'h305: mtvec_d   = {w_data_s[31:2], 1'b0, w_data_s[0]};
      12'h341: mepc_d    = {w_data_s[31:1], 1'b0};
      12'h342: mcause_d  = w_data_s;
      12'h343: mtval_d   = w_data_s;
      12'h344: mip_d     = w_data_s & MIP_SW_MASK;
      12'h100: mstatus_d = (mstatus_q & ~SSTATUS_MASK) | (w_data_s & SSTATUS_MASK);
      12'h104: mie_d     = (mie_q & ~mideleg_q) | (w_data_s & mideleg_q);
      12'h105: stvec_d   = {w_data_s[31:2], 1'b0, w_data_s[0]};
      12'h141: sepc_d    = {w_data_s[31:1], 1'b0};
      12'h142: scause_d  = w_data_s;
      12'h143: stval_d   = w_data_s;
      12'h144: mip_d     = {mip_q[31:2], mideleg_q[1] ? w_data_s[1] : mip_q[1], mip_q[0]};
      12'h180: satp_d    = w_data_s;
      12'hB00: mcycle_d   = {mcycle_q[63:32], w_data_s};
      12'hB80: mcycle_d   = {w_data_s, mcycle_q[31:0]};
      12'hB02: minstret_d = {minstret_q[63:32], w_data_s};
      12'hB82: minstret_d = {w_data_s, minstret_q[31:0]};
      default: mstatus_d = mstatus_q;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q   <= 32'h0000_0000;
      mtvec_q     <= MTVEC_RESET;
      mepc_q      <= 32'h0000_0000;
      mcause_q    <= 32'h0000_0000;
      mtval_q     <= 32'h0000_0000;
      mie_q       <= 32'h0000_0000;
      mip_q       <= 32'h0000_0000;
      medeleg_q   <= 32'h0000_0000;
      mideleg_q   <= 32'h0000_0000;
      stvec_q     <= 32'h0000_0000;
      sepc_q      <= 32'h0000_0000;
      scause_q    <= 32'h0000_0000;
      stval_q     <= 32'h0000_0000;
      satp_q      <= 32'h0000_0000;
      mcycle_q    <= 64'd0;
      minstret_q  <= 64'd0;
      priv_q      <= 2'b11;
      mtip_q      <= 1'b0;
      inst_drop_q <= 1'b0;
    end else begin
      mstatus_q   <= mstatus_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      mie_q       <= mie_d;
      mip_q       <= mip_d;
      medeleg_q   <= medeleg_d;
      mideleg_q   <= mideleg_d;
      stvec_q     <= stvec_d;
      sepc_q      <= sepc_d;
      scause_q    <= scause_d;
      stval_q     <= stval_d;
      satp_q      <= satp_d;
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      priv_q      <= priv_d;
      mtip_q      <= mtip_d;
      inst_drop_q <= inst_drop_d;
    end
  end

  // Read port reflects registered state only; pending writes are not bypassed.
  always_comb begin
    case (bus.raddr_i)
      12'h300: rdata_s = mstatus_q;
      12'h301: rdata_s = MISA_VAL;
      12'h302: rdata_s = medeleg_q;
      12'h303: rdata_s = mideleg_q;
      12'h304: rdata_s = mie_q;
      12'h305: rdata_s = mtvec_q;
      12'h341: rdata_s = mepc_q;
      12'h342: rdata_s = mcause_q;
      12'h343: rdata_s = mtval_q;
      12'h344: rdata_s = mip_view_s;
      12'h100: rdata_s = sstatus_view_s;
      12'h104: rdata_s = sie_view_s;
      12'h105: rdata_s = stvec_q;
      12'h141: rdata_s = sepc_q;
      12'h142: rdata_s = scause_q;
      12'h143: rdata_s = stval_q;
      12'h144: rdata_s = sip_view_s;
      12'h180: rdata_s = satp_q;
      12'hB00, 12'hC00: rdata_s = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata_s = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata_s = minstret_q[31:0];
      12'hB82, 12'hC82: rdata_s = minstret_q[63:32];
      12'hF14: rdata_s = 32'h0000_0000;
      default: rdata_s = 32'h0000_0000;
    endcase
    illegal_s = (bus.rd_valid_i && !addr_known(bus.raddr_i)) ||
                (bus.inst_we_i && !addr_writable(bus.inst_waddr_i));
  end

  assign bus.rdata_o     = rdata_s;
  assign bus.illegal_o   = illegal_s;
  assign bus.inst_drop_o = inst_drop_q;
  assign privilege_o     = priv_q;

  assign csr_mstatus_o = mstatus_q;
  assign csr_mtvec_o   = mtvec_q;
  assign csr_mepc_o    = mepc_q;
  assign csr_mcause_o  = mcause_q;
  assign csr_mtval_o   = mtval_q;
  assign csr_mie_o     = mie_q;
  assign csr_mip_o     = mip_view_s;
  assign csr_medeleg_o = medeleg_q;
  assign csr_mideleg_o = mideleg_q;
  assign csr_stvec_o   = stvec_q;
  assign csr_sepc_o    = sepc_q;
  assign csr_scause_o  = scause_q;
  assign csr_stval_o   = stval_q;
  assign csr_sstatus_o = sstatus_view_s;
  assign csr_sie_o     = sie_view_s;
  assign csr_sip_o     = sip_view_s;
  assign csr_satp_o    = satp_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed-vector bench for csr_regfile with hand-computed expected values.
module tb_csr_regfile;
  logic        clk;
  logic        rst;
  logic        priv_we_i;
  logic [1:0]  priv_i;
  logic [1:0]  privilege_o;
  logic        mtip_i;
  logic        instret_i;
  logic [31:0] csr_mstatus_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mtval_o;
  logic [31:0] csr_mie_o, csr_mip_o, csr_medeleg_o, csr_mideleg_o, csr_stvec_o;
  logic [31:0] csr_sepc_o, csr_scause_o, csr_stval_o, csr_sstatus_o, csr_sie_o;
  logic [31:0] csr_sip_o, csr_satp_o;
  int n_cmp;
  int n_err;

  csr_regfile_if bus ();

  csr_regfile dut (
    .clk(clk), .rst(rst), .bus(bus),
    .priv_we_i(priv_we_i), .priv_i(priv_i), .privilege_o(privilege_o),
    .mtip_i(mtip_i), .instret_i(instret_i),
    .csr_mstatus_o(csr_mstatus_o), .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o),
    .csr_mcause_o(csr_mcause_o), .csr_mtval_o(csr_mtval_o), .csr_mie_o(csr_mie_o),
    .csr_mip_o(csr_mip_o), .csr_medeleg_o(csr_medeleg_o), .csr_mideleg_o(csr_mideleg_o),
    .csr_stvec_o(csr_stvec_o), .csr_sepc_o(csr_sepc_o), .csr_scause_o(csr_scause_o),
    .csr_stval_o(csr_stval_o), .csr_sstatus_o(csr_sstatus_o), .csr_sie_o(csr_sie_o),
    .csr_sip_o(csr_sip_o), .csr_satp_o(csr_satp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.raddr_i = a;
    #1;
    check_eq(tag, {32'h0, bus.rdata_o}, {32'h0, exp});
  endtask

  task automatic wr_trap(input logic [11:0] a, input logic [31:0] d);
    bus.trap_we_i = 1'b1; bus.trap_waddr_i = a; bus.trap_wdata_i = d;
    tick();
    bus.trap_we_i = 1'b0;
  endtask

  task automatic wr_inst(input logic [11:0] a, input logic [31:0] d);
    bus.inst_we_i = 1'b1; bus.inst_waddr_i = a; bus.inst_wdata_i = d;
    tick();
    bus.inst_we_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; priv_we_i = 1'b0; priv_i = 2'b00; mtip_i = 1'b0; instret_i = 1'b0;
    bus.trap_we_i = 1'b0; bus.trap_waddr_i = 12'h000; bus.trap_wdata_i = 32'h0;
    bus.inst_we_i = 1'b0; bus.inst_waddr_i = 12'h000; bus.inst_wdata_i = 32'h0;
    bus.raddr_i = 12'h305; bus.rd_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state and first counter values
    rd_chk("rst_mtvec", 12'h305, 32'h8000_0000);
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    check_eq("rst_priv", {62'h0, privilege_o}, 64'h3);
    check_eq("rst_drop", {63'h0, bus.inst_drop_o}, 64'h0);
    check_eq("rst_mip", {32'h0, csr_mip_o}, 64'h0);
    rd_chk("rst_mcycle", 12'hB00, 32'h0);
    tick(); rd_chk("mcycle_1", 12'hB00, 32'h1);
    tick(); rd_chk("mcycle_2", 12'hB00, 32'h2);
    tick(); rd_chk("mcycle_3", 12'hB00, 32'h3);

    // no write bypass on the read port
    bus.trap_we_i = 1'b1; bus.trap_waddr_i = 12'h343; bus.trap_wdata_i = 32'h55;
    rd_chk("no_bypass", 12'h343, 32'h0);
    tick(); bus.trap_we_i = 1'b0;
    rd_chk("mtval_wr", 12'h343, 32'h55);

    // collision: trap wins, instruction write dropped
    bus.inst_we_i = 1'b1; bus.inst_waddr_i = 12'h341; bus.inst_wdata_i = 32'h0000_1234;
    wr_trap(12'h341, 32'h8000_0103);
    bus.inst_we_i = 1'b0;
    check_eq("coll_mepc", {32'h0, csr_mepc_o}, 64'h8000_0102);
    check_eq("drop_pulse", {63'h0, bus.inst_drop_o}, 64'h1);
    tick();
    check_eq("drop_clear", {63'h0, bus.inst_drop_o}, 64'h0);

    // supervisor views
    wr_trap(12'h303, 32'h0000_0222);
    wr_inst(12'h104, 32'hFFFF_FFFF);
    check_eq("sie_mie", {32'h0, csr_mie_o}, 64'h222);
    rd_chk("sie_rd", 12'h104, 32'h0000_0222);
    wr_inst(12'h100, 32'hFFFF_FFFF);
    check_eq("sstatus_mst", {32'h0, csr_mstatus_o}, 64'h000C_0122);
    rd_chk("sstatus_rd", 12'h100, 32'h000C_0122);

    // WARL fields
    wr_inst(12'h300, 32'h0000_1800);
    wr_inst(12'h300, 32'h0000_1000);
    check_eq("mpp_keep", {32'h0, csr_mstatus_o}, 64'h0000_1800);
    wr_trap(12'h305, 32'h1234_5677);
    check_eq("mtvec_warl", {32'h0, csr_mtvec_o}, 64'h1234_5675);
    wr_inst(12'h105, 32'hFFFF_FFFF);
    check_eq("stvec_warl", {32'h0, csr_stvec_o}, 64'hFFFF_FFFD);
    wr_inst(12'h141, 32'h0000_0003);
    check_eq("sepc_warl", {32'h0, csr_sepc_o}, 64'h2);
    wr_inst(12'h142, 32'h8000_0009);
    check_eq("scause", {32'h0, csr_scause_o}, 64'h8000_0009);

    // counter carry and illegal write to the read-only shadow
    wr_inst(12'hB80, 32'h0);
    wr_inst(12'hB00, 32'hFFFF_FFFE);
    rd_chk("cyc_fe", 12'hB00, 32'hFFFF_FFFE);
    rd_chk("cyc_fe_hi", 12'hB80, 32'h0);
    tick(); rd_chk("cyc_ff", 12'hC00, 32'hFFFF_FFFF);
    tick(); rd_chk("cyc_wrap_lo", 12'hB00, 32'h0);
    rd_chk("cyc_wrap_hi", 12'hC80, 32'h1);
    bus.inst_we_i = 1'b1; bus.inst_waddr_i = 12'hC00; bus.inst_wdata_i = 32'h0000_DEAD;
    #1 check_eq("ill_c00", {63'h0, bus.illegal_o}, 64'h1);
    tick(); bus.inst_we_i = 1'b0;
    rd_chk("cyc_after_ill", 12'hB00, 32'h1);
    rd_chk("cyc_after_ill_hi", 12'hB80, 32'h1);
    bus.rd_valid_i = 1'b1; bus.raddr_i = 12'h123;
    #1 check_eq("ill_rd", {63'h0, bus.illegal_o}, 64'h1);
    check_eq("unk_rd0", {32'h0, bus.rdata_o}, 64'h0);
    bus.rd_valid_i = 1'b0;
    #1 check_eq("ill_rd_idle", {63'h0, bus.illegal_o}, 64'h0);
    bus.rd_valid_i = 1'b1;
    rd_chk("misa", 12'h301, 32'h4014_1101);

    // minstret holds without retire, counts with it
    wr_inst(12'hB02, 32'h7);
    tick(); tick();
    rd_chk("instret_hold", 12'hC02, 32'h7);
    instret_i = 1'b1; tick(); instret_i = 1'b0;
    rd_chk("instret_inc", 12'hB02, 32'h8);

    // timer pending bit
    mtip_i = 1'b1;
    #1 check_eq("mtip_wait", {32'h0, csr_mip_o}, 64'h0);
    tick();
    check_eq("mtip_set", {32'h0, csr_mip_o}, 64'h80);
    wr_inst(12'h344, 32'h0);
    check_eq("mtip_ro", {32'h0, csr_mip_o}, 64'h80);
    wr_trap(12'h344, 32'hFFFF_FFFF);
    check_eq("mip_sw", {32'h0, csr_mip_o}, 64'h2A2);
    wr_inst(12'h144, 32'h0);
    check_eq("sip_wr", {32'h0, csr_mip_o}, 64'h2A0);
    rd_chk("sip_rd", 12'h144, 32'h0000_0220);

    // asynchronous reset mid-operation
    wr_inst(12'hB82, 32'h1);
    wr_inst(12'hB02, 32'h5);
    wr_inst(12'hB80, 32'h1);
    priv_we_i = 1'b1; priv_i = 2'b01;
    wr_inst(12'hB00, 32'h5);
    priv_we_i = 1'b0;
    check_eq("pre_priv", {62'h0, privilege_o}, 64'h1);
    rd_chk("pre_cyc", 12'hB00, 32'h5);
    rd_chk("pre_inst_hi", 12'hB82, 32'h1);
    rst = 1'b1;
    #1 check_eq("arst_priv", {62'h0, privilege_o}, 64'h3);
    rd_chk("arst_cyc_lo", 12'hB00, 32'h0);
    rd_chk("arst_cyc_hi", 12'hB80, 32'h0);
    rd_chk("arst_inst_lo", 12'hB02, 32'h0);
    rd_chk("arst_inst_hi", 12'hB82, 32'h0);
    rd_chk("arst_mtvec", 12'h305, 32'h8000_0000);
    check_eq("arst_mepc", {32'h0, csr_mepc_o}, 64'h0);
    check_eq("arst_mip", {32'h0, csr_mip_o}, 64'h0);
    check_eq("arst_mie", {32'h0, csr_mie_o}, 64'h0);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine/supervisor CSR storage, the responder for the trap controller's sequential one-CSR-per-cycle write port and the pipeline's CSR instruction write-back.
- Holds the architectural trap CSRs, the privilege level and the 64-bit cycle/instret counters.
- Exports every CSR as a flat output for the trap controller, and provides one combinational read port for CSR instructions.
- sstatus/sie/sip are masked views of mstatus/mie/mip.

Parameters:
- MTVEC_RESET, 32'h8000_0000, reset value of mtvec.
- MISA_VAL, 32'h4014_1101, constant value read from misa (0x301).
- SSTATUS_MASK, 32'h000C_0122, mstatus bits visible/writable through sstatus (SIE, SPIE, SPP, SUM, MXR).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- trap_we_i  in  1  trap-controller write enable
- trap_waddr_i  in  12  trap-controller write address
- trap_wdata_i  in  32  trap-controller write data
- inst_we_i  in  1  CSR-instruction write enable (WB stage)
- inst_waddr_i  in  12  CSR-instruction write address
- inst_wdata_i  in  32  CSR-instruction write data (already RMW-resolved)
- raddr_i  in  12  read address
- rd_valid_i  in  1  read port in use
- rdata_o  out  32  read data, combinational
- illegal_o  out  1  combinational; unknown raddr with rd_valid_i, or inst write to a read-only/unknown address
- inst_drop_o  out  1  registered pulse: an instruction write was discarded due to a collision
- priv_we_i  in  1  privilege update
- priv_i  in  2  new privilege
- privilege_o  out  2  current privilege
- mtip_i  in  1  machine timer compare flag
- instret_i  in  1  one instruction retired this cycle
- csr_mstatus_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mtval_o, csr_mie_o, csr_mip_o, csr_medeleg_o, csr_mideleg_o, csr_stvec_o, csr_sepc_o, csr_scause_o, csr_stval_o, csr_sstatus_o, csr_sie_o, csr_sip_o, csr_satp_o  out  32 each  register values

Behaviour:
- Reset values:
  - All stored CSRs 0, except mtvec=MTVEC_RESET.
  - privilege_o=2'b11.
  - mcycle=minstret=0.
  - inst_drop_o=0.
  - mip.MTIP=0.
- Write arbitration:
  - All writes commit at posedge clk.
  - trap port has absolute priority.
  - If trap_we_i and inst_we_i are both high, the instruction write is discarded and inst_drop_o=1 for the next cycle.
- Read timing:
  - rdata_o reflects register state only; no write bypass.
  - A write in cycle N is visible on rdata_o and the csr_*_o outputs in cycle N+1.
- Address map:
  - Machine: 0x300 mstatus, 0x301 misa (RO const), 0x304 mie, 0x305 mtvec, 0x302 medeleg, 0x303 mideleg, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip.
  - Supervisor: 0x100 sstatus, 0x104 sie, 0x105 stvec, 0x141 sepc, 0x142 scause, 0x143 stval, 0x144 sip, 0x180 satp.
  - Counters: 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi, 0xC00/0xC80 cycle (RO), 0xC02/0xC82 instret (RO).
  - Identification: 0xF14 mhartid (RO, 0).
  - Unknown address: reads 0, write ignored.
- WARL rules:
  - mtvec/stvec bit1 forced 0.
  - mepc/sepc bit0 forced 0.
  - mcause/scause stored in full.
  - mstatus MPP: write of 2'b10 retains the old value.
- Supervisor views:
  - sstatus read = mstatus & SSTATUS_MASK.
  - sstatus write: mstatus = (mstatus & ~SSTATUS_MASK) | (wdata & SSTATUS_MASK).
  - sie read = mie & mideleg; sie write updates only mie bits set in mideleg.
  - sip read = mip & mideleg; sip write is limited to SSIP (bit1) where delegated.
- mip:
  - MTIP (bit7) is read-only and equals mtip_i registered by one cycle.
  - Writes to bit7 are ignored from both ports.
  - SSIP(1), STIP(5), SEIP(9) are writable via 0x344.
- Counters:
  - mcycle increments by 1 every cycle.
  - minstret increments when instret_i=1.
  - A write to a half replaces that half at the posedge, and the increment is suppressed that cycle (written value exact).
  - Low half 0xFFFF_FFFF +1 carries into the high half.
  - 64-bit wrap to 0.
- Privilege:
  - privilege_o <= priv_i when priv_we_i.
  - An independent port; may coincide with a CSR write.
- illegal_o:
  - Raised for a write to a 0xCxx address, misa, mhartid, or an unknown address.
  - Raised for a read from an unknown address.
  - Purely combinational, no state change.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); counters restart from 0.

Test Plan:
- Reset, then read 0x305 and 0x300 -> 32'h8000_0000 and 0; privilege_o=2'b11; mcycle counts 1,2,3 in successive cycles.
- Same cycle: trap write 0x341=0x8000_0103 and inst write 0x341=0x1234 -> next cycle mepc=0x8000_0102; inst_drop_o=1 for exactly one cycle.
- mideleg=0x222, then sie write 0xFFFF_FFFF -> mie=0x222; sie reads 0x222. Then sstatus write 0xFFFF_FFFF -> mstatus=0x000C_0122.
- Write mcycle lo=0xFFFF_FFFE, hi=0 -> reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then lo=0 with hi=1. minstret holds when instret_i=0.
- mtip_i=1 -> mip bit7 set one cycle later. Write 0x344=0 -> bit7 stays 1. Write 0xC00 -> illegal_o=1 and cycle is unaffected.
- Assert rst while counters=0x1_0000_0005 and privilege=01 -> all outputs return to reset values without a clock edge.
